line_sched: RTL and testbench
=============================

LINE_SCHED -- requirements
Module: line_sched

Interface
REQ-001 SHALL have parameter CORDW, default 16, meaning signed coordinate width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester command valid; bit i is requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester command accept.
REQ-006 SHALL have port req_cmd  input  8*CORDW  two packed commands; requester i occupies bits [4*CORDW*(i+1)-1 : 4*CORDW*i], ordered {x0,y0,x1,y1} MSB first, each signed CORDW.
REQ-007 SHALL have port req_done  output  2  per-requester completion pulse.
REQ-008 SHALL have port eng_start  output  1  start pulse to the line engine.
REQ-009 SHALL have port eng_x0, eng_y0, eng_x1, eng_y1  output  CORDW each, signed  endpoints driven to the line engine.
REQ-010 SHALL have port eng_oe  output  1  line engine output enable.
REQ-011 SHALL have port eng_done  input  1  engine completion, high for one cycle.
REQ-012 SHALL have port pix_ready  input  1  pixel sink can accept a pixel this cycle.
REQ-013 SHALL have port owner  output  1  requester ID of the line in progress.
REQ-014 SHALL have port busy  output  1  high from accept until completion.
REQ-015 SHALL have port line_cnt  output  16  count of completed lines, wraps 0xFFFF->0.

Function
REQ-016 SHALL implement FSM IDLE -> START -> WAIT -> IDLE.
REQ-017 IDLE: req_ready[i] SHALL be combinational: state==IDLE && grant[i]; at most one bit set.
REQ-018 Grant: one valid -> grant it; both valid -> grant requester equal to priority pointer prio.
REQ-019 Acceptance (valid[i] && ready[i]) SHALL latch that command into eng_x0..eng_y1, set owner=i, busy=1 and go to START.
REQ-020 START: eng_start SHALL be 1 for exactly this one cycle, then go to WAIT.
REQ-021 WAIT: eng_oe SHALL equal pix_ready; eng_oe SHALL be 0 in every other state.
REQ-022 eng_x0..eng_y1 SHALL be held stable from the cycle after acceptance until the cycle after eng_done.
REQ-023 WAIT with eng_done=1 SHALL, on the next edge: pulse req_done[owner] for one cycle, set prio = ~owner, increment line_cnt, clear busy, return to IDLE.
REQ-024 Accept-to-eng_start latency SHALL be 1 cycle; eng_done-to-next-accept minimum SHALL be 1 cycle (back-to-back lines).
REQ-025 eng_done outside WAIT SHALL be ignored: no req_done pulse, no count.
REQ-026 req_valid deasserted before acceptance SHALL withdraw the request with no side effect.
REQ-027 req_valid changes during START/WAIT SHALL not affect the line in progress.
REQ-028 Coordinates SHALL pass through unmodified; endpoint ordering and swapping belong to the engine.

Reset
REQ-029 rst SHALL asynchronously force: state=IDLE, prio=0, owner=0, busy=0, req_done=0, eng_start=0, line_cnt=0, eng_x0..eng_y1=0.
REQ-030 rst asserted in START/WAIT SHALL abandon the line with no req_done pulse; the engine SHALL share the same rst net at top level.
REQ-031 First accept after rst deassertion SHALL be possible on the first clock edge.

Structure
REQ-032 State encoding localparams (IDLE/START/WAIT, STATEW=2) and requester count (2) SHALL live in the shared gfx package.
REQ-033 One sub-module SHALL be used: rr_arb2, a two-way round-robin grant (inputs valid[1:0], prio; output grant[1:0]); everything else inline.

Verification
REQ-034 Single line: req_valid=01, cmd0={0,0,5,3}; engine model asserts eng_done 8 cycles after start -> ready[0] same cycle, eng_start 1 cycle later, req_done=01 one cycle after eng_done, line_cnt=1.
REQ-035 Contention: req_valid=11 held after reset -> order 0,1,0,1 across four lines; req_done alternates 01/10; line_cnt=4.
REQ-036 Backpressure: toggle pix_ready 1,0,0,1 during WAIT -> eng_oe mirrors it exactly; eng_x0..eng_y1 constant throughout.
REQ-037 Reset mid-line: assert rst 3 cycles into WAIT -> immediate IDLE, busy=0, no req_done pulse, line_cnt=0; a new request is accepted on the first edge after release.
REQ-038 Spurious done plus wrap: pulse eng_done in IDLE -> no effect; preload line_cnt to 0xFFFF, complete one line -> line_cnt=0x0000.

Source files
------------

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics constants: scheduler state encoding and requester count
package gfx_pkg;
  localparam int STATEW = 2;
  localparam int NREQ   = 2;

  localparam logic [STATEW-1:0] IDLE  = 2'd0;
  localparam logic [STATEW-1:0] START = 2'd1;
  localparam logic [STATEW-1:0] WAIT  = 2'd2;

  typedef enum logic [STATEW-1:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_WAIT  = WAIT
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; prio picks the winner only under contention
module rr_arb2
  import gfx_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            prio,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/line_sched.sv
// rtl/line_sched.sv - arbitrates two line-draw requesters onto one line engine
module line_sched
  import gfx_pkg::*;
#(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [8*CORDW-1:0]      req_cmd,
  output logic [NREQ-1:0]         req_done,
  output logic                    eng_start,
  output logic signed [CORDW-1:0] eng_x0,
  output logic signed [CORDW-1:0] eng_y0,
  output logic signed [CORDW-1:0] eng_x1,
  output logic signed [CORDW-1:0] eng_y1,
  output logic                    eng_oe,
  input  logic                    eng_done,
  input  logic                    pix_ready,
  output logic                    owner,
  output logic                    busy,
  output logic [15:0]             line_cnt
);

  state_t              state, state_nx;
  logic                prio;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     accept;
  logic [4*CORDW-1:0]  sel_cmd;
  logic                finish;

  rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio),
    .grant (grant)
  );

  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign accept    = req_valid & req_ready;
  assign finish    = (state == S_WAIT) && eng_done;
  assign sel_cmd   = accept[1] ? req_cmd[8*CORDW-1:4*CORDW] : req_cmd[4*CORDW-1:0];

  always_comb begin
    state_nx  = state;
    eng_start = 1'b0;
    eng_oe    = 1'b0;
    case (state)
      S_IDLE:  if (|accept) state_nx = S_START;
      S_START: begin
        eng_start = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        eng_oe = pix_ready;
        if (eng_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Endpoints are only loaded on accept, so they stay frozen through START/WAIT and the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      req_done <= '0;
      line_cnt <= '0;
      eng_x0   <= '0;
      eng_y0   <= '0;
      eng_x1   <= '0;
      eng_y1   <= '0;
    end else begin
      req_done <= '0;
      if (|accept) begin
        eng_x0 <= sel_cmd[4*CORDW-1 -: CORDW];
        eng_y0 <= sel_cmd[3*CORDW-1 -: CORDW];
        eng_x1 <= sel_cmd[2*CORDW-1 -: CORDW];
        eng_y1 <= sel_cmd[CORDW-1 -: CORDW];
        owner  <= accept[1];
        busy   <= 1'b1;
      end
      if (finish) begin
        req_done <= {owner, ~owner};
        prio     <= ~owner;
        line_cnt <= line_cnt + 16'd1;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_sched.sv
// tb/tb_line_sched.sv - self-checking bench for line_sched with a transaction-level model
module tb_line_sched;
  localparam int CORDW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [8*CORDW-1:0] req_cmd;
  logic [1:0]         req_done;
  logic               eng_start;
  logic signed [CORDW-1:0] eng_x0, eng_y0, eng_x1, eng_y1;
  logic               eng_oe;
  logic               eng_done;
  logic               pix_ready;
  logic               owner;
  logic               busy;
  logic [15:0]        line_cnt;

  logic [63:0] cmd0, cmd1, coords;
  int checks = 0;
  int errors = 0;
  int model_prio;
  int model_cnt;

  assign req_cmd = {cmd1, cmd0};
  assign coords  = {eng_x0, eng_y0, eng_x1, eng_y1};

  always #5 clk = ~clk;

  line_sched #(.CORDW(CORDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_done(req_done), .eng_start(eng_start),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .eng_oe(eng_oe), .eng_done(eng_done), .pix_ready(pix_ready),
    .owner(owner), .busy(busy), .line_cnt(line_cnt)
  );

  typedef struct {
    logic [1:0] valid;
    logic [1:0] ready;
  } arb_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", req_done, 0);
    check("rst_start", eng_start, 0);
    check("rst_oe", eng_oe, 0);
    check("rst_owner", owner, 0);
    check("rst_cnt", line_cnt, 0);
    check("rst_coords", coords, 0);
    model_prio = 0;
    model_cnt  = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete line: request, accept, dly WAIT cycles with eng_done on the last, then completion.
  task automatic do_line(input logic [1:0] v, input int dly, input logic [7:0] pix_pat, input bit rnd);
    int w;
    logic [63:0] exp_cmd;
    w = (v == 2'b11) ? model_prio : (v[1] ? 1 : 0);
    exp_cmd = (w == 1) ? cmd1 : cmd0;
    req_valid = v;
    #1;
    check("ready", req_ready, 64'(1) << w);
    @(posedge clk);
    @(negedge clk);
    if (rnd) begin
      req_valid = 2'($urandom);
      cmd0 = {$urandom, $urandom};
      cmd1 = {$urandom, $urandom};
    end
    #1;
    check("start", eng_start, 1);
    check("busy_start", busy, 1);
    check("owner", owner, w);
    check("coords_latch", coords, exp_cmd);
    check("done_width", req_done, 0);
    check("ready_in_start", req_ready, 0);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      pix_ready = rnd ? 1'($urandom) : pix_pat[d];
      eng_done  = (d == dly - 1);
      if (rnd) req_valid = 2'($urandom);
      #1;
      check("start_once", eng_start, 0);
      check("oe_mirror", eng_oe, pix_ready);
      check("coords_hold", coords, exp_cmd);
      check("ready_in_wait", req_ready, 0);
      check("no_early_done", req_done, 0);
    end
    @(negedge clk);
    eng_done  = 1'b0;
    req_valid = 2'b00;
    model_cnt  = (model_cnt + 1) & 16'hFFFF;
    model_prio = 1 - w;
    #1;
    check("req_done", req_done, 64'(1) << w);
    check("busy_clear", busy, 0);
    check("line_cnt", line_cnt, model_cnt);
    check("coords_after", coords, exp_cmd);
    check("oe_idle", eng_oe, 0);
  endtask

  initial begin
    arb_vec_t vecs[4];
    vecs[0] = '{valid: 2'b00, ready: 2'b00};
    vecs[1] = '{valid: 2'b01, ready: 2'b01};
    vecs[2] = '{valid: 2'b10, ready: 2'b10};
    vecs[3] = '{valid: 2'b11, ready: 2'b01};

    req_valid = 2'b00;
    eng_done  = 1'b0;
    pix_ready = 1'b1;
    cmd0 = '0;
    cmd1 = '0;
    @(negedge clk);
    do_reset();

    // Arbitration at reset priority; each request is withdrawn before an edge can accept it.
    for (int i = 0; i < 4; i++) begin
      req_valid = vecs[i].valid;
      #1;
      check("arb_ready", req_ready, vecs[i].ready);
      req_valid = 2'b00;
      @(negedge clk);
      check("withdraw_busy", busy, 0);
      check("withdraw_cnt", line_cnt, 0);
    end

    cmd0 = {16'd0, 16'd0, 16'd5, 16'd3};
    cmd1 = {$urandom, $urandom};
    do_line(2'b01, 8, 8'hFF, 1'b0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd0 = {$urandom, $urandom};
      cmd1 = {$urandom, $urandom};
      do_line(2'b11, 2 + i, 8'hFF, 1'b0);
    end
    check("contention_cnt", line_cnt, 4);

    cmd1 = {16'hFFF0, 16'h0007, 16'h8000, 16'h7FFF};
    do_line(2'b10, 4, 8'b0000_1001, 1'b0);

    // Reset three cycles into WAIT abandons the line.
    do_reset();
    cmd0 = {$urandom, $urandom};
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_oe", eng_oe, 0);
    check("midrst_start", eng_start, 0);
    check("midrst_done", req_done, 0);
    check("midrst_cnt", line_cnt, 0);
    check("midrst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_prio = 0;
    model_cnt  = 0;
    cmd0 = {$urandom, $urandom};
    do_line(2'b01, 3, 8'hFF, 1'b0);

    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("spurious_done", req_done, 0);
    check("spurious_cnt", line_cnt, model_cnt);
    check("spurious_busy", busy, 0);

    force dut.line_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.line_cnt;
    #1;
    check("preload_cnt", line_cnt, 16'hFFFF);
    model_cnt = 16'hFFFF;
    cmd0 = {$urandom, $urandom};
    cmd1 = {$urandom, $urandom};
    do_line(2'b11, 2, 8'hFF, 1'b0);
    check("wrap_cnt", line_cnt, 0);

    for (int i = 0; i < 25; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      cmd0 = {$urandom, $urandom};
      cmd1 = {$urandom, $urandom};
      do_line(v, $urandom_range(1, 6), 8'h00, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
